// File: rtl/serial_encoder.sv
// LSB-first parallel-to-serial encoder with valid/ready load and optional inversion.
// Define SERIAL_ENCODER_PARITY_EN to append an even-parity bit to every frame.
module serial_encoder #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          INVERT     = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] parallelIn,
  input  logic             loadValid,
  output logic             loadReady,
  output logic             serialOut,
  output logic             frameSync,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
`ifdef SERIAL_ENCODER_PARITY_EN
  localparam logic [CW-1:0] LAST = CW'(WIDTH);
`else
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`endif

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic [WIDTH-1:0] sh_q, sh_n;
  logic             serial_q, serial_n;
  logic             sync_q, sync_n;
  logic             done_q, done_n;
  logic             ready_q, ready_n;
  logic [WIDTH-1:0] enc;
  logic             accept;
  logic [CW-1:0]    cnt_inc;
`ifdef SERIAL_ENCODER_PARITY_EN
  logic             parity_q, parity_n;
`endif

  assign enc     = INVERT ? ~parallelIn : parallelIn;
  assign accept  = loadValid & ready_q;
  assign cnt_inc = cnt_q + CW'(1);

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sh_q     <= '0;
      serial_q <= IDLE_LEVEL;
      sync_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
`ifdef SERIAL_ENCODER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      sh_q     <= sh_n;
      serial_q <= serial_n;
      sync_q   <= sync_n;
      done_q   <= done_n;
      ready_q  <= ready_n;
`ifdef SERIAL_ENCODER_PARITY_EN
      parity_q <= parity_n;
`endif
    end
  end

  // Next-state logic; an accept always restarts a frame, including on the last bit
  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    sh_n     = sh_q;
    serial_n = serial_q;
    sync_n   = 1'b0;
    done_n   = 1'b0;
    ready_n  = ready_q;
`ifdef SERIAL_ENCODER_PARITY_EN
    parity_n = parity_q;
`endif
    if (accept) begin
      state_n  = SHIFT;
      cnt_n    = '0;
      sh_n     = enc >> 1;
      serial_n = enc[0];
      sync_n   = 1'b1;
      ready_n  = 1'b0;
`ifdef SERIAL_ENCODER_PARITY_EN
      parity_n = ^enc;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          serial_n = IDLE_LEVEL;
          ready_n  = 1'b1;
        end
        SHIFT: begin
          if (cnt_q == LAST) begin
            state_n  = IDLE;
            cnt_n    = '0;
            serial_n = IDLE_LEVEL;
            ready_n  = 1'b1;
          end else begin
            cnt_n    = cnt_inc;
            sh_n     = sh_q >> 1;
            serial_n = sh_q[0];
`ifdef SERIAL_ENCODER_PARITY_EN
            if (cnt_q == CW'(WIDTH - 1)) serial_n = parity_q;
`endif
            done_n   = (cnt_inc == LAST);
            ready_n  = (cnt_inc == LAST);
          end
        end
        default: begin
          state_n  = IDLE;
          serial_n = IDLE_LEVEL;
          ready_n  = 1'b1;
        end
      endcase
    end
  end

  assign serialOut = serial_q;
  assign frameSync = sync_q;
  assign done      = done_q;
  assign loadReady = ready_q;

endmodule

// File: tb/tb_serial_encoder.sv
// Directed self-checking bench for serial_encoder (WIDTH=8).
// Build with SERIAL_ENCODER_PARITY_EN to exercise the parity frame instead of the plain-frame cases.
module tb_serial_encoder;

  localparam int unsigned W = 8;
`ifdef SERIAL_ENCODER_PARITY_EN
  localparam bit INV = 1'b0;
  localparam int FL  = 9;
`else
  localparam bit INV = 1'b1;
  localparam int FL  = 8;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] parallelIn = '0;
  logic         loadValid = 1'b0;
  logic         loadReady, serialOut, frameSync, done;

  int n_vec = 0;
  int n_err = 0;

  serial_encoder #(.WIDTH(W), .INVERT(INV), .IDLE_LEVEL(1'b0)) dut (
    .clock(clock), .reset(reset), .parallelIn(parallelIn), .loadValid(loadValid),
    .loadReady(loadReady), .serialOut(serialOut), .frameSync(frameSync), .done(done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    check({tag, ".ser"},   32'(serialOut), 32'd0);
    check({tag, ".rdy"},   32'(loadReady), 32'd1);
    check({tag, ".sync"},  32'(frameSync), 32'd0);
    check({tag, ".done"},  32'(done),      32'd0);
  endtask

  // Bit k of a stream of back-to-back frames of length FL
  task automatic chk_bit(input string tag, input int k, input logic [31:0] vec);
    string t;
    t = $sformatf("%s.b%0d", tag, k);
    check({t, ".ser"},  32'(serialOut), 32'(vec[k]));
    check({t, ".sync"}, 32'(frameSync), 32'((k % FL) == 0));
    check({t, ".done"}, 32'(done),      32'((k % FL) == FL - 1));
    check({t, ".rdy"},  32'(loadReady), 32'((k % FL) == FL - 1));
  endtask

  initial begin
    // Reset then idle
    @(negedge clock);
    chk_idle("rst");
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk_idle($sformatf("idle%0d", i));
    end

`ifndef SERIAL_ENCODER_PARITY_EN
    // Single frame: ~A5 = 5A
    parallelIn = 8'hA5; loadValid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (k == 0) loadValid = 1'b0;
      chk_bit("single", k, 32'h5A);
    end
    @(negedge clock);
    chk_idle("single.end");

    // Back-to-back: A5 then 0F with valid held; change lands while busy and is ignored
    parallelIn = 8'hA5; loadValid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clock);
      if (k == 0) parallelIn = 8'h0F;
      if (k == 8) loadValid = 1'b0;
      chk_bit("b2b", k, 32'hF05A);
    end
    @(negedge clock);
    chk_idle("b2b.end");

    // Busy ignore: FF offered from bit 2, taken only at done
    parallelIn = 8'hA5; loadValid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clock);
      if (k == 0) loadValid = 1'b0;
      if (k == 2) begin parallelIn = 8'hFF; loadValid = 1'b1; end
      if (k == 8) loadValid = 1'b0;
      chk_bit("busy", k, 32'h005A);
    end
    @(negedge clock);
    chk_idle("busy.end");

    // Mid-frame reset during bit 4, then a clean frame from bit 0
    parallelIn = 8'hA5; loadValid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      if (k == 0) loadValid = 1'b0;
      chk_bit("mrst", k, 32'h5A);
    end
    #1 reset = 1'b1;
    #1 chk_idle("mrst.async");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk_idle("mrst.rel");
    parallelIn = 8'h0F; loadValid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (k == 0) loadValid = 1'b0;
      chk_bit("mrst.next", k, 32'hF0);
    end
    @(negedge clock);
    chk_idle("mrst.end");
`else
    // Parity: 07 -> 1,1,1,0,0,0,0,0 then parity 1
    parallelIn = 8'h07; loadValid = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clock);
      if (k == 0) loadValid = 1'b0;
      chk_bit("par", k, 32'h107);
    end
    @(negedge clock);
    chk_idle("par.end");
    // Parity of an even-weight word is 0
    parallelIn = 8'h03; loadValid = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clock);
      if (k == 0) loadValid = 1'b0;
      chk_bit("par0", k, 32'h003);
    end
    @(negedge clock);
    chk_idle("par0.end");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_encoder.md
Name: serial_encoder

Overview:
- Transmit-side partner of the SIPO serial decoder.
- Accepts a WIDTH-bit parallel word through a valid/ready handshake, optionally inverts it, and shifts it out LSB-first on a single serial line, one bit per clock.
- The bit order and inversion match the decoder: the decoder's SIPO plus its end-of-frame XOR returns the original word.
- Sits between the parallel data source and the serial link.

Parameters:
- WIDTH, 8, data bits per frame (minimum 2).
- INVERT, 1, 1 = transmit the bitwise complement of parallelIn; 0 = transmit it unchanged.
- IDLE_LEVEL, 0, value driven on serialOut when no frame is active.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- parallelIn  input  WIDTH  word to transmit; sampled only on the accept edge.
- loadValid  input  1  source has a word on parallelIn.
- loadReady  output  1  encoder can accept a word this cycle.
- serialOut  output  1  registered serial data, LSB first.
- frameSync  output  1  high for exactly the cycle in which bit 0 of a frame is on serialOut.
- done  output  1  high for exactly the cycle in which the final bit of a frame is on serialOut.

Behaviour:
- Reset (async, active-high) values:
  - state = IDLE, bit counter = 0, shift register = 0.
  - serialOut = IDLE_LEVEL, frameSync = 0, done = 0, loadReady = 1.
  - Reset asserted mid-frame aborts the frame immediately; no partial bits continue after release.
- Encoded word: enc = INVERT ? ~parallelIn : parallelIn, captured on the accept edge.
- Accept: at a rising edge where loadValid & loadReady are both high.
- States: IDLE, SHIFT.
- IDLE:
  - loadReady = 1, serialOut = IDLE_LEVEL.
  - On accept: go to SHIFT, serialOut <= enc[0], frameSync <= 1, shift register <= enc >> 1, counter <= 0.
- SHIFT:
  - Each edge: serialOut <= next shift-register LSB, counter increments, frameSync <= 0.
  - Cycle k after the accept edge (k = 0..WIDTH-1) carries enc[k].
  - Latency from the accept edge to bit 0 on serialOut is 1 edge (bit 0 is visible in the cycle right after the accept edge).
- Last bit (counter == WIDTH-1):
  - done = 1 and loadReady = 1.
  - If accepted here: the next edge starts the new frame with no gap (serialOut <= enc'[0], frameSync <= 1).
  - Otherwise: return to IDLE and drive IDLE_LEVEL.
- Outside IDLE and the last-bit cycle, loadReady = 0; loadValid is ignored and parallelIn changes have no effect.
- Counter width: $clog2(WIDTH+1); it never exceeds WIDTH, with no wrap beyond the frame.
- All outputs are registered or decoded from registered state only; there is no combinational path from loadValid to loadReady.

Optional Feature:
- Macro: SERIAL_ENCODER_PARITY_EN.
- Defined:
  - An extra bit is sent after enc[WIDTH-1]: even parity = XOR of all WIDTH transmitted bits.
  - Frame length becomes WIDTH+1.
  - done and loadReady move to the parity-bit cycle.
  - Back-to-back accept is allowed during the parity cycle.
- Undefined: frame is exactly WIDTH bits; no parity logic is present.

Test Plan:
1. Reset then idle: reset=1 for 2 cycles, release, loadValid=0 for 5 cycles -> serialOut=0, loadReady=1, frameSync=0, done=0 throughout.
2. Single frame: WIDTH=8, INVERT=1, parallelIn=8'hA5, one-cycle loadValid -> serialOut sequence 0,1,0,1,1,0,1,0 on the 8 cycles after accept; frameSync on the first of these cycles; done on the eighth; then IDLE.
3. Back-to-back: 8'hA5 then 8'h0F, with loadValid held high -> second accept on the done cycle; 16 consecutive bits 0,1,0,1,1,0,1,0,0,0,0,0,1,1,1,1 with no gap; frameSync high twice, 8 cycles apart.
4. Busy ignore: during cycle 3 of a frame, change parallelIn to 8'hFF with loadValid=1 -> loadReady=0; current frame bits unchanged; 8'hFF is accepted only on the done cycle.
5. Mid-frame reset: assert reset during bit 4 -> serialOut=0 and loadReady=1 immediately, without waiting for a clock edge; the next accepted word is sent from bit 0.
6. Parity (SERIAL_ENCODER_PARITY_EN defined, INVERT=0, 8'h07) -> bits 1,1,1,0,0,0,0,0 then parity 1; done on the 9th bit.
